// File: rtl/id_branch_unit_pkg.sv
// Shared definitions for the ID-stage branch resolver: branch encodings,
// FSM states and forwarding-source indices.
package id_branch_unit_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Forwarding sources are ordered youngest first.
    localparam int FWD_EX  = 0;
    localparam int FWD_MEM = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/id_branch_unit_fwd_operand_sel.sv
// Priority operand mux over NFWD forwarding sources (index 0 youngest);
// flags a hazard when the winning source is not yet ready.
module fwd_operand_sel #(
    parameter int XLEN = 32,
    parameter int NFWD = 2
) (
    input  logic [4:0]           addr,
    input  logic [XLEN-1:0]      rf_data,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD*5-1:0]    fwd_rd,
    input  logic [NFWD-1:0]      fwd_ready,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    output logic [XLEN-1:0]      data,
    output logic                 hazard
);

    logic found;

    always_comb begin
        data   = (addr == 5'd0) ? '0 : rf_data;
        hazard = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < NFWD; i++) begin
            // First match wins; older matches are shadowed even when ready.
            if (!found && addr != 5'd0 && fwd_valid[i] && fwd_rd[i*5 +: 5] == addr) begin
                found  = 1'b1;
                data   = fwd_data[i*XLEN +: XLEN];
                hazard = !fwd_ready[i];
            end
        end
    end

endmodule

// File: rtl/id_branch_unit.sv
// ID-stage branch resolver: forwarded operand select, condition evaluation,
// producer-wait stall, registered redirect pulse and saturating counters.
import id_branch_unit_pkg::*;

module id_branch_unit #(
    parameter int XLEN = 32,
    parameter int NFWD = 2,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_in,
    input  logic                 id_valid,
    input  logic                 is_branch,
    input  logic [2:0]           funct3,
    input  logic [4:0]           rs1_addr,
    input  logic [4:0]           rs2_addr,
    input  logic [XLEN-1:0]      rs1_data,
    input  logic [XLEN-1:0]      rs2_data,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD*5-1:0]    fwd_rd,
    input  logic [NFWD-1:0]      fwd_ready,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    output logic                 stall,
    output logic                 br_valid,
    output logic                 br_taken,
    output logic                 br_illegal,
    output logic [CNTW-1:0]      stall_cycles,
    output logic [CNTW-1:0]      taken_count
);

    logic [XLEN-1:0] op1, op2;
    logic            hz1, hz2, hazard, req, resolve;
    logic            taken, illegal, eq, lt, ltu;
    state_t          state_q, state_d;

    fwd_operand_sel #(.XLEN(XLEN), .NFWD(NFWD)) u_sel_rs1 (
        .addr(rs1_addr), .rf_data(rs1_data), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
        .fwd_ready(fwd_ready), .fwd_data(fwd_data), .data(op1), .hazard(hz1)
    );

    fwd_operand_sel #(.XLEN(XLEN), .NFWD(NFWD)) u_sel_rs2 (
        .addr(rs2_addr), .rf_data(rs2_data), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
        .fwd_ready(fwd_ready), .fwd_data(fwd_data), .data(op2), .hazard(hz2)
    );

    assign req     = id_valid && is_branch && !flush_in;
    assign hazard  = hz1 || hz2;
    // Gated by rst_n so every output is low while reset is held.
    assign stall   = req && hazard && rst_n;
    assign resolve = req && !hazard;

    assign eq  = (op1 == op2);
    assign lt  = ($signed(op1) < $signed(op2));
    assign ltu = (op1 < op2);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = !eq;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = !lt;
            F3_BLTU: taken = ltu;
            F3_BGEU: taken = !ltu;
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req && hazard) state_d = ST_WAIT;
            ST_WAIT: if (!req || !hazard) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            br_valid     <= 1'b0;
            br_taken     <= 1'b0;
            br_illegal   <= 1'b0;
            stall_cycles <= '0;
            taken_count  <= '0;
        end else begin
            state_q    <= state_d;
            br_valid   <= resolve;
            br_taken   <= resolve && taken;
            br_illegal <= resolve && illegal;
            if (stall && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
            if (resolve && taken && taken_count != '1)
                taken_count <= taken_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_branch_unit.sv
// Bench for id_branch_unit: directed scenarios plus randomized traffic,
// checked against a behavioural model of the branch rules.
module tb_id_branch_unit;

    localparam int XLEN = 32;
    localparam int NFWD = 2;
    localparam int CNTW = 16;
    localparam int CMAX = (1 << CNTW) - 1;

    logic                 clk, rst_n, flush_in, id_valid, is_branch;
    logic [2:0]           funct3;
    logic [4:0]           rs1_addr, rs2_addr;
    logic [XLEN-1:0]      rs1_data, rs2_data;
    logic [NFWD-1:0]      fwd_valid, fwd_ready;
    logic [NFWD*5-1:0]    fwd_rd;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic                 stall, br_valid, br_taken, br_illegal;
    logic [CNTW-1:0]      stall_cycles, taken_count;

    id_branch_unit #(.XLEN(XLEN), .NFWD(NFWD), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .flush_in(flush_in), .id_valid(id_valid),
        .is_branch(is_branch), .funct3(funct3), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
        .fwd_ready(fwd_ready), .fwd_data(fwd_data), .stall(stall), .br_valid(br_valid),
        .br_taken(br_taken), .br_illegal(br_illegal), .stall_cycles(stall_cycles),
        .taken_count(taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    logic m_bv, m_bt, m_bi;
    int   m_sc, m_tc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Scan oldest to youngest so the youngest matching source overwrites last.
    function automatic logic [32:0] pick(input logic [4:0] a, input logic [31:0] rf);
        logic [32:0] r;
        r = {1'b0, (a == 5'd0) ? 32'd0 : rf};
        for (int i = NFWD - 1; i >= 0; i--)
            if (a != 5'd0 && fwd_valid[i] && fwd_rd[i*5 +: 5] == a)
                r = {!fwd_ready[i], fwd_data[i*XLEN +: XLEN]};
        return r;
    endfunction

    // Returns {illegal, taken}.
    function automatic logic [1:0] cond(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int signed sa, sb;
        sa = a; sb = b;
        case (f)
            3'd0: return {1'b0, a == b};
            3'd1: return {1'b0, a != b};
            3'd4: return {1'b0, sa < sb};
            3'd5: return {1'b0, sa >= sb};
            3'd6: return {1'b0, a < b};
            3'd7: return {1'b0, a >= b};
            default: return 2'b10;
        endcase
    endfunction

    task automatic clear_in();
        flush_in = 0; id_valid = 0; is_branch = 0; funct3 = 0;
        rs1_addr = 0; rs2_addr = 0; rs1_data = 0; rs2_data = 0;
        fwd_valid = 0; fwd_rd = 0; fwd_ready = '1; fwd_data = 0;
    endtask

    task automatic model_clear();
        m_bv = 0; m_bt = 0; m_bi = 0; m_sc = 0; m_tc = 0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".br_valid"}, {31'd0, br_valid}, {31'd0, m_bv});
        chk({tag, ".br_taken"}, {31'd0, br_taken}, {31'd0, m_bt});
        chk({tag, ".br_illegal"}, {31'd0, br_illegal}, {31'd0, m_bi});
        chk({tag, ".stall_cycles"}, {16'd0, stall_cycles}, m_sc);
        chk({tag, ".taken_count"}, {16'd0, taken_count}, m_tc);
    endtask

    // Called at posedge+1 with inputs already set; returns at the next posedge+1.
    task automatic cycle(input string tag);
        logic [32:0] o1, o2;
        logic        rq, hz;
        logic [1:0]  c;
        o1 = pick(rs1_addr, rs1_data);
        o2 = pick(rs2_addr, rs2_data);
        rq = id_valid && is_branch && !flush_in;
        hz = o1[32] || o2[32];
        c  = cond(funct3, o1[31:0], o2[31:0]);
        #3;
        chk({tag, ".stall"}, {31'd0, stall}, {31'd0, rq && hz});
        if (rq && hz && m_sc < CMAX) m_sc++;
        m_bv = rq && !hz;
        m_bt = m_bv && c[0];
        m_bi = m_bv && c[1];
        if (m_bt && m_tc < CMAX) m_tc++;
        @(posedge clk); #1;
        check_regs(tag);
    endtask

    task automatic do_reset();
        clear_in();
        rst_n = 0;
        model_clear();
        @(posedge clk); #1;
        check_regs("reset");
        chk("reset.stall", {31'd0, stall}, 0);
        rst_n = 1;
    endtask

    task automatic branch(input logic [2:0] f, input logic [4:0] a1, input logic [31:0] d1,
                          input logic [4:0] a2, input logic [31:0] d2);
        id_valid = 1; is_branch = 1; funct3 = f;
        rs1_addr = a1; rs1_data = d1; rs2_addr = a2; rs2_data = d2;
    endtask

    initial begin
        clear_in();
        rst_n = 1;
        #1 rst_n = 0;
        #1;
        do_reset();

        // Signed vs unsigned less-than on the same operands.
        branch(3'b100, 5'd1, 32'hFFFF_FFFF, 5'd2, 32'd1);
        cycle("blt");
        chk("blt.taken", {31'd0, br_taken}, 1);
        branch(3'b110, 5'd1, 32'hFFFF_FFFF, 5'd2, 32'd1);
        cycle("bltu");
        chk("bltu.taken", {31'd0, br_taken}, 0);

        // Youngest source wins over an older ready source.
        branch(3'b000, 5'd5, 32'd100, 5'd6, 32'd7);
        fwd_valid = 2'b11; fwd_rd = {5'd5, 5'd5}; fwd_ready = 2'b11;
        fwd_data = {32'd9, 32'd7};
        cycle("beq_fwd");
        chk("beq_fwd.taken", {31'd0, br_taken}, 1);

        // Two-cycle producer wait.
        do_reset();
        branch(3'b001, 5'd5, 32'd0, 5'd6, 32'd3);
        fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd5}; fwd_ready = 2'b10; fwd_data = {32'd0, 32'd3};
        cycle("bne_w1");
        cycle("bne_w2");
        chk("bne.stall_cnt", {16'd0, stall_cycles}, 2);
        fwd_ready = 2'b11; fwd_data = {32'd0, 32'd4};
        cycle("bne_res");
        chk("bne.resolved", {31'd0, br_valid & br_taken}, 1);

        // Flush while waiting aborts without a redirect.
        fwd_ready = 2'b10;
        cycle("fl_wait");
        flush_in = 1;
        cycle("fl_kill");
        chk("flush.no_bv", {31'd0, br_valid}, 0);
        flush_in = 0; fwd_ready = 2'b11;
        cycle("fl_after");

        // Reserved funct3, then x0 ignores a forwarding source that targets it.
        clear_in();
        branch(3'b010, 5'd1, 32'd1, 5'd1, 32'd1);
        cycle("illegal");
        chk("illegal.flag", {31'd0, br_illegal}, 1);
        branch(3'b000, 5'd0, 32'd77, 5'd3, 32'd0);
        fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd0}; fwd_data = {32'd0, 32'd5}; fwd_ready = 2'b10;
        cycle("x0");
        chk("x0.taken", {31'd0, br_taken}, 1);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] pool [5];
            pool[0] = 32'd0; pool[1] = 32'd1; pool[2] = 32'hFFFF_FFFF; pool[3] = 32'h8000_0000;
            pool[4] = $urandom;
            flush_in  = ($urandom_range(0, 9) == 0);
            id_valid  = ($urandom_range(0, 9) != 0);
            is_branch = ($urandom_range(0, 9) != 0);
            funct3    = 3'($urandom_range(0, 7));
            rs1_addr  = 5'($urandom_range(0, 3));
            rs2_addr  = 5'($urandom_range(0, 3));
            rs1_data  = pool[$urandom_range(0, 4)];
            rs2_data  = pool[$urandom_range(0, 4)];
            for (int i = 0; i < NFWD; i++) begin
                fwd_valid[i]          = $urandom_range(0, 1) == 1;
                fwd_rd[i*5 +: 5]      = 5'($urandom_range(0, 3));
                fwd_ready[i]          = $urandom_range(0, 3) != 0;
                fwd_data[i*XLEN +: XLEN] = pool[$urandom_range(0, 4)];
            end
            cycle("rand");
        end

        // Async reset mid-stall clears everything without a clock edge.
        clear_in();
        branch(3'b000, 5'd1, 32'd4, 5'd2, 32'd4);
        cycle("pre_rst");
        fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd1}; fwd_ready = 2'b10;
        #2 rst_n = 0;
        #1;
        chk("arst.stall", {31'd0, stall}, 0);
        chk("arst.br_valid", {31'd0, br_valid}, 0);
        chk("arst.br_taken", {31'd0, br_taken}, 0);
        chk("arst.stall_cycles", {16'd0, stall_cycles}, 0);
        chk("arst.taken_count", {16'd0, taken_count}, 0);
        model_clear();
        @(posedge clk); #1;
        rst_n = 1;

        // Taken counter saturation.
        clear_in();
        branch(3'b000, 5'd1, 32'd4, 5'd2, 32'd4);
        for (int n = 0; n < (1 << CNTW) + 3; n++) cycle("sat");
        chk("sat.taken_count", {16'd0, taken_count}, 32'h0000_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_branch_unit.md
Name: id_branch_unit

Overview:
- ID-stage branch resolver for the 5-stage RV32 pipeline.
- Selects operands from the register file or from N forwarding sources (youngest first), and evaluates all six conditional branches.
- Holds the front end while a needed producer is not yet ready, e.g. a load in EX.
- Emits a registered redirect and keeps saturating performance counters.

Parameters:
XLEN, 32, datapath width
NFWD, 2, number of forwarding sources; index 0 = youngest (EX), 1 = MEM, ...
CNTW, 16, width of performance counters

Ports:
clk  in  1  pipeline clock
rst_n  in  1  reset; asynchronous, active-low
flush_in  in  1  kill of the ID instruction by an older redirect
id_valid  in  1  ID holds a valid instruction
is_branch  in  1  instruction is a conditional branch
funct3  in  3  branch condition
rs1_addr, rs2_addr  in  5 each  source register indices
rs1_data, rs2_data  in  XLEN each  register-file read data
fwd_valid  in  NFWD  source i will write a register
fwd_rd  in  NFWD*5  destination index of source i
fwd_ready  in  NFWD  source i data is final this cycle
fwd_data  in  NFWD*XLEN  result of source i
stall  out  1  freeze PC and IF/ID (combinational)
br_valid  out  1  registered one-cycle pulse: branch resolved
br_taken  out  1  registered: condition true (valid with br_valid)
br_illegal  out  1  registered: funct3 010/011 (valid with br_valid)
stall_cycles  out  CNTW  saturating count of branch stall cycles
taken_count  out  CNTW  saturating count of taken branches

Behaviour:
- Reset (rst_n low, async): FSM = IDLE; br_valid, br_taken, br_illegal, stall_cycles, taken_count = 0.
- Operand select, per operand, applied independently to rs1 and rs2:
  - Match on source i: fwd_valid[i] && fwd_rd[i] == addr && addr != 0.
  - The lowest matching index wins; with no match, use the register-file data.
  - addr == 0 always yields 0.
- Hazard: the winning match has fwd_ready[i] == 0. Older matches are ignored even if they are ready.
- Active request: req = id_valid && is_branch && !flush_in.
- stall = req && hazard, in the same cycle (combinational).
- Compare on XLEN bits:
  - 000 BEQ: eq
  - 001 BNE: !eq
  - 100 BLT: signed rs1 < rs2
  - 101 BGE: !BLT
  - 110 BLTU: unsigned rs1 < rs2
  - 111 BGEU: !BLTU
  - 010/011: taken = 0, illegal = 1
- FSM IDLE:
  - req && hazard: go to WAIT.
  - req && !hazard: resolve. Next cycle br_valid = 1 with br_taken/br_illegal. Stay in IDLE.
- FSM WAIT:
  - stall is asserted while the hazard persists.
  - When the hazard clears: resolve using the now-ready forwarded data, then go to IDLE.
  - If req drops (flush_in or id_valid = 0): abort to IDLE with no br_valid.
- Latency: resolution is 1 cycle after the first hazard-free req cycle. Back-to-back branches resolve on consecutive cycles.
- br_valid / br_taken / br_illegal are single-cycle pulses, cleared in the following cycle unless another resolve occurs.
- Counters:
  - stall_cycles increments on every cycle with stall = 1.
  - taken_count increments on every resolve with taken = 1.
  - Both saturate at all-ones.
- flush_in has priority over everything except reset. Reset asserted mid-WAIT returns to IDLE immediately.

Decomposition:
- Shared package: funct3 branch encodings (BEQ..BGEU), FSM state enum, forwarding-source index constants.
- One sub-module, fwd_operand_sel: a parametrised NFWD priority mux that returns data plus a hazard flag. Instantiate it twice, once for rs1 and once for rs2.

Test Plan:
- BLT, rs1 = 0xFFFFFFFF, rs2 = 1, no forwarding -> br_valid next cycle, br_taken = 1. Same operands with BLTU -> br_taken = 0.
- BEQ x5, x6: source 0 writes x5 = 7 and source 1 writes x5 = 9, both ready; rs2 = 7 -> source 0 wins, taken = 1, stall never asserted.
- BNE: x5 match on source 0 with fwd_ready = 0 for 2 cycles -> stall high for 2 cycles, stall_cycles = 2; br_valid is 1 cycle after ready rises.
- Branch in WAIT, then flush_in asserted -> stall drops the same cycle, no br_valid, FSM in IDLE.
- funct3 = 010 -> br_illegal = 1, br_taken = 0. rs1_addr = 0 with a source writing x0 = 5 -> operand reads 0.
- Drive 2^CNTW + 3 taken branches -> taken_count holds at all-ones. Async rst_n pulse mid-stall -> all outputs 0 without waiting for a clock edge.
